kulisch_acc_drain: RTL and testbench
====================================

# kulisch_acc_drain

Owns the Kulisch accumulator state register pair (sum/carry, carry-save form) that closes the feedback loop around the combinational `kulisch_acc_fp16` CSA stage, and drains the final dot-product result. On the last accumulation step it resolves the redundant pair with a chunked carry-propagate adder. It then normalizes and rounds (RNE) the 92-bit two's-complement fixed-point value to IEEE-754 FP32, and presents the result on a valid/ready output port.

## Interface
- `AWIDTH`, 92: accumulator width; two's complement, wraps mod 2^AWIDTH.
- `FRAC_BITS`, 48: bit i has weight 2^(i-FRAC_BITS).
- `NCHUNK`, 4: CPA chunks; chunk width CW = AWIDTH/NCHUNK = 23.
- `CNT_W`, 16: step-counter width.
- Reset is asynchronous and active-low; the block has one clock.
- `clk`  in  1  clock.
- `rst_n`  in  1  async active-low reset.
- `i_sum_nxt`  in  AWIDTH  CSA tree sum output.
- `i_carry_nxt`  in  AWIDTH  CSA tree carry output.
- `i_valid`  in  1  tree outputs represent a valid step.
- `i_last`  in  1  qualifies the final step of a dot product.
- `o_ready`  out  1  step accepted when `i_valid && o_ready`.
- `o_sum_acc`  out  AWIDTH  registered sum, fed to the tree's `i_sum_acc`.
- `o_carry_acc`  out  AWIDTH  registered carry, fed to the tree's `i_carry_acc`.
- `o_count`  out  CNT_W  steps accepted in the current dot product; saturates at all-ones.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts the result.
- `o_result`  out  32  FP32 result.
- `o_inexact`  out  1  rounding discarded nonzero bits.

## Operation
- Reset values: state ACC, `o_sum_acc` = 0, `o_carry_acc` = 0, `o_count` = 0, `o_valid` = 0, `o_result` = 0, `o_inexact` = 0.
- FSM: ACC → CPA → NORM → ROUND → OUT → ACC.
- ACC
  - `o_ready` = 1 in this state only.
  - On an accepted step: the sum/carry registers load `i_sum_nxt`/`i_carry_nxt`, and `o_count` increments.
  - If `i_last` is set on the accepted step: go to CPA.
  - `i_last` without `i_valid` is ignored.
- CPA
  - Lasts NCHUNK cycles. Cycle j adds chunk j (LSB first) of sum and carry plus the registered chunk carry-in.
  - The result goes into a separate AWIDTH result register S. The carry out of the top chunk is discarded (mod 2^AWIDTH).
  - The sum/carry registers hold their values in this state.
- NORM (1 cycle)
  - s = S[AWIDTH-1]; M = |S| as an AWIDTH-bit unsigned value. S = -2^91 gives M = 2^91.
  - p = index of the leading one of M, from the sub-module.
  - zero = (M == 0).
- ROUND (1 cycle)
  - Exponent E = p - FRAC_BITS + 127. The range 79..170 means no subnormal and no overflow.
  - Fraction = M[p-1:p-23]. Bits below index 0 read as 0 when p < 23.
  - Guard g = M[p-24]. Sticky st = OR of M[p-25:0].
  - Round up iff g && (st || lsb). A mantissa carry-out increments E.
  - `o_inexact` = g | st.
  - Zero produces `o_result` = 0x00000000 (+0) and `o_inexact` = 0.
- OUT
  - `o_valid` = 1. `o_result` and `o_inexact` are held stable until `i_ready`.
  - On handshake: sum/carry registers, S and `o_count` clear to 0; `o_valid` drops the next cycle; return to ACC.
- Accumulator overflow (wrap mod 2^92) is not detected.
- Async reset in any state forces the reset values immediately. An in-flight result is lost.

## Timing
- Last step accepted at edge T: CPA runs T+1..T+4, NORM at T+5, `o_valid` rises after edge T+6.
- Latency from last accept to result is NCHUNK+2 cycles.
- Result handshake at edge U: `o_ready` = 1 from after edge U, so a new step can be accepted at edge U+1.
- Steady-state throughput: one step per cycle while in ACC.
- `o_sum_acc`/`o_carry_acc` change only at accepted-step edges and at the clear on handshake.
- The CSA-tree → register path is the critical loop. The CPA is chunked to keep the adder off that path.

## Structure
- Shared package `kulisch_pkg` holds:
  - AWIDTH and FRAC_BITS.
  - FP32 constants: EXP_W = 8, MAN_W = 23, BIAS = 127.
  - The FSM state enum {ACC, CPA, NORM, ROUND, OUT}.
  - A CPA chunk-index width derived from NCHUNK.
- One sub-module, `kulisch_lzc`: parameterized AWIDTH-bit leading-one detector, combinational.
  - Outputs: p (ceil(log2(AWIDTH)) bits) and zero.

## Test plan
- Single step, sum = 1<<48, carry = 0, `i_last` = 1 → `o_result` 0x3F800000, `o_inexact` 0, `o_valid` after edge T+6, `o_count` 1.
- Split redundant pair: sum = (1<<48)+(1<<47), carry = all-ones (-1) then +1 (i.e. carry = 1<<0, sum reduced by 1) over 3 steps → 0x3FC00000 (1.5), with carries crossing all chunk boundaries.
- Rounding:
  - S = (1<<48)+(1<<24) → tie to even → 0x3F800000, inexact 1.
  - S = (1<<48)+3·(1<<24) → 0x3F800002, inexact 1.
- Extremes:
  - S = -2^91 (MSB only) → 0xD5000000.
  - S = 1 (2^-48) → 0x27800000.
  - S = 0 → 0x00000000, inexact 0.
- Backpressure: hold `i_ready` = 0 for 5 cycles in OUT → `o_result` stable, `o_ready` = 0, steps with `i_valid` = 1 not accepted and `o_count` unchanged; accept → registers 0, `o_ready` = 1 next cycle.
- Reset asserted during CPA cycle 2 → all outputs at reset values immediately, state ACC. A subsequent 1.0 dot product returns 0x3F800000.

Source files
------------

// File: rtl/kulisch_pkg.sv
// kulisch_pkg: shared constants and types for the Kulisch accumulator drain.
//   AWIDTH / FRAC_BITS : fixed-point accumulator format (bit i weighs 2^(i-FRAC_BITS))
//   NCHUNK             : default number of chunks in the carry-propagate adder
//   EXP_W / MAN_W / BIAS : IEEE-754 binary32 field widths and exponent bias
//   state_t            : drain FSM states
package kulisch_pkg;

  localparam int AWIDTH    = 92;
  localparam int FRAC_BITS = 48;
  localparam int NCHUNK    = 4;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // Width of the CPA chunk index; at least one bit even for a single chunk.
  function automatic int chunk_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CIDX_W = chunk_idx_w(NCHUNK);

  typedef enum logic [2:0] {ACC, CPA, NORM, ROUND, OUT} state_t;

endpackage

// File: rtl/kulisch_lzc.sv
// kulisch_lzc: combinational leading-one detector.
//   m    : AWIDTH-bit unsigned magnitude
//   p    : index of the most significant set bit of m (0 when m == 0)
//   zero : m is all zeros
module kulisch_lzc #(
  parameter int AWIDTH = 92,
  parameter int PW     = $clog2(AWIDTH)
) (
  input  logic [AWIDTH-1:0] m,
  output logic [PW-1:0]     p,
  output logic              zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    p = '0;
    for (int i = 0; i < AWIDTH; i++)
      if (m[i]) p = PW'(i);
  end

  assign zero = ~|m;

endmodule

// File: rtl/kulisch_acc_drain.sv
// kulisch_acc_drain: carry-save accumulator register pair plus result drain.
//   i_sum_nxt/i_carry_nxt/i_valid/i_last/o_ready : step input from the CSA tree
//   o_sum_acc/o_carry_acc : registered redundant accumulator, fed back to the tree
//   o_count               : accepted steps in the current dot product (saturating)
//   o_valid/i_ready/o_result/o_inexact : FP32 result port (RNE rounding)
// After the last step the pair is resolved by a chunked CPA (one chunk per
// cycle, LSB first), then normalized and rounded to FP32.
module kulisch_acc_drain #(
  parameter int AWIDTH    = kulisch_pkg::AWIDTH,
  parameter int FRAC_BITS = kulisch_pkg::FRAC_BITS,
  parameter int NCHUNK    = kulisch_pkg::NCHUNK,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] i_sum_nxt,
  input  logic [AWIDTH-1:0] i_carry_nxt,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [AWIDTH-1:0] o_sum_acc,
  output logic [AWIDTH-1:0] o_carry_acc,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_result,
  output logic              o_inexact
);
  import kulisch_pkg::*;

  localparam int CW   = AWIDTH / NCHUNK;
  localparam int PW   = $clog2(AWIDTH);
  localparam int CI_W = chunk_idx_w(NCHUNK);

  state_t state, nxt;

  logic [AWIDTH-1:0] sum_acc, carry_acc, res, mag;
  logic [CNT_W-1:0]  count;
  logic [CI_W-1:0]   cidx;
  logic              cin, sign, is_zero;
  logic [PW-1:0]     lead;

  logic accept, handshake;
  assign accept    = o_ready && i_valid;
  assign handshake = o_valid && i_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else        state <= nxt;

  // ---------------- FSM: next state ----------------
  always_comb begin
    nxt = state;
    case (state)
      ACC:   if (i_valid && i_last) nxt = CPA;
      CPA:   if (cidx == CI_W'(NCHUNK - 1)) nxt = NORM;
      NORM:  nxt = ROUND;
      ROUND: nxt = OUT;
      OUT:   if (i_ready) nxt = ACC;
      default: nxt = ACC;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_ready = (state == ACC);
    o_valid = (state == OUT);
  end

  // ---------------- CPA chunk ----------------
  logic [CW:0] csum;
  assign csum = {1'b0, sum_acc[cidx*CW +: CW]} + {1'b0, carry_acc[cidx*CW +: CW]}
              + {{CW{1'b0}}, cin};

  // ---------------- normalize ----------------
  logic [AWIDTH-1:0] mag_c;
  logic [PW-1:0]     lead_c;
  logic              zero_c;

  // -2^(AWIDTH-1) negates to itself, which read unsigned is exactly 2^(AWIDTH-1).
  assign mag_c = res[AWIDTH-1] ? -res : res;

  kulisch_lzc #(.AWIDTH(AWIDTH), .PW(PW)) u_lzc (
    .m    (mag_c),
    .p    (lead_c),
    .zero (zero_c)
  );

  // ---------------- round ----------------
  // Shift the leading one up to bit AWIDTH-1 (dropped); bits below 0 fill with zeros.
  logic [PW-1:0]     shamt;
  logic [AWIDTH-2:0] norm;
  logic [MAN_W-1:0]  frac;
  logic              guard, sticky, up;
  logic [MAN_W:0]    man_r;
  logic [EXP_W-1:0]  exp_r;
  logic [31:0]       rounded;
  logic              inexact;

  always_comb begin
    shamt   = PW'(AWIDTH - 1) - lead;
    norm    = (AWIDTH-1)'(mag << shamt);
    frac    = norm[AWIDTH-2 -: MAN_W];
    guard   = norm[AWIDTH-2-MAN_W];
    sticky  = |norm[AWIDTH-3-MAN_W:0];
    up      = guard & (sticky | frac[0]);
    man_r   = {1'b0, frac} + {{MAN_W{1'b0}}, up};
    // Mantissa carry-out leaves the fraction at zero and bumps the exponent.
    exp_r   = EXP_W'(lead) + EXP_W'(BIAS - FRAC_BITS) + {{(EXP_W-1){1'b0}}, man_r[MAN_W]};
    rounded = is_zero ? 32'h0 : {sign, exp_r, man_r[MAN_W-1:0]};
    inexact = is_zero ? 1'b0 : (guard | sticky);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc   <= '0;
      carry_acc <= '0;
      count     <= '0;
      res       <= '0;
      cin       <= 1'b0;
      cidx      <= '0;
      mag       <= '0;
      sign      <= 1'b0;
      lead      <= '0;
      is_zero   <= 1'b0;
      o_result  <= '0;
      o_inexact <= 1'b0;
    end else begin
      if (accept) begin
        sum_acc   <= i_sum_nxt;
        carry_acc <= i_carry_nxt;
        if (count != '1) count <= count + 1'b1;
      end
      if (state == CPA) begin
        res[cidx*CW +: CW] <= csum[CW-1:0];
        cin                <= csum[CW];
        cidx               <= cidx + 1'b1;
      end else begin
        cin  <= 1'b0;
        cidx <= '0;
      end
      if (state == NORM) begin
        sign    <= res[AWIDTH-1];
        mag     <= mag_c;
        lead    <= lead_c;
        is_zero <= zero_c;
      end
      if (state == ROUND) begin
        o_result  <= rounded;
        o_inexact <= inexact;
      end
      if (handshake) begin
        sum_acc   <= '0;
        carry_acc <= '0;
        res       <= '0;
        count     <= '0;
      end
    end
  end

  assign o_sum_acc   = sum_acc;
  assign o_carry_acc = carry_acc;
  assign o_count     = count;

endmodule

// File: tb/tb_kulisch_acc_drain.sv
module tb_kulisch_acc_drain;
  localparam int AW = 92;
  localparam logic [AW-1:0] ONE  = AW'(1) << 48;
  localparam logic [AW-1:0] HALF = AW'(1) << 47;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] i_sum_nxt, i_carry_nxt, o_sum_acc, o_carry_acc;
  logic i_valid, i_last, o_ready, o_valid, i_ready, o_inexact;
  logic [15:0] o_count;
  logic [31:0] o_result;

  always #5 clk = ~clk;

  kulisch_acc_drain dut (
    .clk(clk), .rst_n(rst_n),
    .i_sum_nxt(i_sum_nxt), .i_carry_nxt(i_carry_nxt),
    .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready),
    .o_sum_acc(o_sum_acc), .o_carry_acc(o_carry_acc), .o_count(o_count),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_inexact(o_inexact)
  );

  // scoreboard entry: {inexact, result}
  typedef logic [32:0] exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer-division style rounding of the magnitude.
  function automatic exp_t model(input logic [AW-1:0] v);
    logic neg, up, inex;
    logic [AW-1:0] m;
    logic [127:0] mant, rem, half;
    logic [7:0] e;
    int p;
    neg = v[AW-1];
    m = v;
    if (neg) m = -v;
    if (m == '0) return '0;
    p = 0;
    for (int i = AW-1; i >= 0; i--) if (m[i]) begin p = i; break; end
    if (p >= 23) begin
      mant = 128'(m) >> (p - 23);
      rem  = 128'(m) & ((128'(1) << (p - 23)) - 128'(1));
      half = (p >= 24) ? (128'(1) << (p - 24)) : 128'(0);
      up   = (p >= 24) && ((rem > half) || (rem == half && mant[0]));
      inex = (rem != 0);
    end else begin
      mant = 128'(m) << (23 - p);
      up = 1'b0;
      inex = 1'b0;
    end
    mant = mant + 128'(up);
    e = 8'(p + 79);
    if (mant[24]) begin mant = mant >> 1; e = e + 8'd1; end
    return {inex, neg, e, mant[22:0]};
  endfunction

  always @(negedge clk)
    if (rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) chk("unexpected_result", o_valid, 0);
      else begin
        mon_e = sb.pop_front();
        chk("result", o_result, mon_e[31:0]);
        chk("inexact", o_inexact, mon_e[32]);
      end
    end

  task automatic step(input logic [AW-1:0] s, input logic [AW-1:0] c, input logic last);
    int n;
    i_sum_nxt = s; i_carry_nxt = c; i_valid = 1'b1; i_last = last;
    n = 0;
    while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("accept_timeout", o_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  function automatic logic [AW-1:0] rnd();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[AW-1:0];
  endfunction

  // One-step dot product with the value split randomly across sum/carry.
  task automatic dp1(input logic [AW-1:0] v, input exp_t e);
    logic [AW-1:0] r;
    r = rnd();
    sb.push_back(e);
    step(v - r, r, 1'b1);
    wait_drain();
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] v;
    rst_n = 1'b0; i_sum_nxt = '0; i_carry_nxt = '0;
    i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_result", o_result, 0);
    chk("rst_inexact", o_inexact, 0);
    chk("rst_sum", o_sum_acc, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0, with latency check
    sb.push_back({1'b0, 32'h3F800000});
    step(ONE, '0, 1'b1);
    chk("t1_count", o_count, 1);
    chk("t1_ready", o_ready, 0);
    chk("t1_sum", o_sum_acc, ONE);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_valid_T+%0d", k), o_valid, (k == 6));
    end
    wait_drain();

    // redundant pair resolved across every chunk boundary (1.5)
    sb.push_back({1'b0, 32'h3FC00000});
    step(rnd(), rnd(), 1'b0);
    step(ONE + HALF - AW'(1), AW'(1), 1'b0);
    step(ONE + HALF + AW'(1), '1, 1'b1);
    chk("t2_count", o_count, 3);
    wait_drain();

    // rounding
    dp1(ONE + (AW'(1) << 24), {1'b1, 32'h3F800000});
    dp1(ONE + (AW'(3) << 24), {1'b1, 32'h3F800002});
    // extremes
    dp1(AW'(1) << 91, {1'b0, 32'hD5000000});
    dp1(AW'(1), {1'b0, 32'h27800000});
    dp1('0, {1'b0, 32'h00000000});
    // random values against the reference
    for (int k = 0; k < 8; k++) begin
      v = rnd() >> $urandom_range(0, 80);
      if (k[0]) v = -v;
      dp1(v, model(v));
    end

    // backpressure
    i_ready = 1'b0;
    sb.push_back({1'b0, 32'h3F800000});
    step(ONE, '0, 1'b1);
    for (int n = 0; n < 20 && !o_valid; n++) begin @(posedge clk); #1; end
    chk("bp_valid", o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_last = 1'b1; i_sum_nxt = rnd(); i_carry_nxt = rnd();
      @(posedge clk); #1;
      chk("bp_result", o_result, 32'h3F800000);
      chk("bp_ready", o_ready, 0);
      chk("bp_count", o_count, 1);
      chk("bp_sum", o_sum_acc, ONE);
    end
    i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    wait_drain();
    chk("hs_ready", o_ready, 1);
    chk("hs_valid", o_valid, 0);
    chk("hs_sum", o_sum_acc, 0);
    chk("hs_carry", o_carry_acc, 0);
    chk("hs_count", o_count, 0);

    // reset during CPA
    sb.push_back({1'b0, 32'h3F800000});
    step(ONE + HALF, HALF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_sum", o_sum_acc, 0);
    chk("mid_rst_carry", o_carry_acc, 0);
    chk("mid_rst_result", o_result, 0);
    chk("mid_rst_inexact", o_inexact, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", o_valid, 0);
    dp1(ONE, {1'b0, 32'h3F800000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
